// File: rtl/mem_read_responder_if.sv
// Request, beat-stream and SRAM read-port signals of the memory read responder.
// Handshakes (req, data) transfer on a rising edge where valid and ready are both 1; a
// valid source holds its payload steady until that edge, and ready may depend on valid.
interface mem_read_responder_if #(
  parameter int BEAT_BYTES     = 32,
  parameter int SRAM_ADDR_BITS = 12
);
  logic                      req_valid;
  logic                      req_ready;
  logic [33:0]               req_len;
  logic [63:0]               req_addr_address;
  logic                      inProgress;
  logic                      data_valid;
  logic                      data_ready;
  logic [BEAT_BYTES*8-1:0]   data;
  logic                      sram_rd_en;
  logic [SRAM_ADDR_BITS-1:0] sram_rd_addr;
  logic [BEAT_BYTES*8-1:0]   sram_rd_data;
  logic                      err;

  modport master (
    output req_valid, req_len, req_addr_address, data_ready, sram_rd_data,
    input  req_ready, inProgress, data_valid, data, sram_rd_en, sram_rd_addr, err
  );

  modport slave (
    input  req_valid, req_len, req_addr_address, data_ready, sram_rd_data,
    output req_ready, inProgress, data_valid, data, sram_rd_en, sram_rd_addr, err
  );
endinterface

// File: rtl/mem_read_responder.sv
// Streams ceil(len/BEAT_BYTES) beats from a 1-cycle-latency SRAM through a 2-entry FIFO,
// starting at the beat that contains the request address.
module mem_read_responder #(
  parameter int BEAT_BYTES     = 32,
  parameter int SRAM_ADDR_BITS = 12
) (
  input  logic                 clock,
  input  logic                 areset,
  mem_read_responder_if.slave  bus,
  output logic                 debug_state
);
  localparam int OFF_BITS = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 0;
  localparam int DW       = BEAT_BYTES * 8;
  localparam int CW       = 35;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      ready_q;
  logic [CW-1:0]             reads_left;
  logic [CW-1:0]             beats_left;
  logic [SRAM_ADDR_BITS-1:0] beat_idx;
  logic                      in_flight;
  logic [DW-1:0]             fifo_mem [2];
  logic                      rd_ptr;
  logic                      wr_ptr;
  logic [1:0]                count;

  logic                      fire;
  logic                      pop;
  logic                      push;
  logic                      last_pop;
  logic                      misaligned;
  logic                      room;
  logic                      issue;
  logic [2:0]                occupancy_next;
  logic [CW-1:0]             req_beats;
  logic [63:0]               req_index_full;
  logic                      unused_index_bits;

  assign req_index_full    = bus.req_addr_address >> OFF_BITS;
  assign unused_index_bits = ^req_index_full;
  assign req_beats         = ({1'b0, bus.req_len} + CW'(BEAT_BYTES - 1)) >> OFF_BITS;
  assign misaligned        = (bus.req_addr_address & 64'(BEAT_BYTES - 1)) != 64'd0;

  assign fire     = bus.req_valid && bus.req_ready;
  assign pop      = (count != 2'd0) && bus.data_ready;
  assign push     = in_flight;
  assign last_pop = pop && (beats_left == CW'(1));

  // A beat popped this cycle frees its slot in time for a read issued now, which keeps
  // the stream at one beat per cycle with only two FIFO entries.
  assign occupancy_next = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
  assign room           = occupancy_next < 3'd2;

  always_ff @(posedge clock or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire && (req_beats != '0)) state_next = STREAM;
      STREAM:  if (last_pop)                  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue          = (state == STREAM) && (reads_left != '0) && room;
    bus.req_ready  = ready_q && (state == IDLE);
    bus.inProgress = (state == STREAM);
    bus.sram_rd_en = issue;
    bus.data_valid = (count != 2'd0);
    bus.data       = fifo_mem[rd_ptr];
    debug_state    = state;
  end

  assign bus.sram_rd_addr = beat_idx;

  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      ready_q     <= 1'b0;
      bus.err     <= 1'b0;
      reads_left  <= '0;
      beats_left  <= '0;
      beat_idx    <= '0;
      in_flight   <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      ready_q   <= 1'b1;
      bus.err   <= fire && misaligned;
      in_flight <= issue;
      if (fire) begin
        beat_idx   <= req_index_full[SRAM_ADDR_BITS-1:0];
        reads_left <= req_beats;
        beats_left <= req_beats;
      end else begin
        if (issue) begin
          beat_idx   <= beat_idx + SRAM_ADDR_BITS'(1);
          reads_left <= reads_left - CW'(1);
        end
        if (pop) beats_left <= beats_left - CW'(1);
      end
      if (push) begin
        fifo_mem[wr_ptr] <= bus.sram_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: SRAM model, request driver, negedge monitor with expected
// queues built from address/length arithmetic, and directed plus random scenarios.
module tb_mem_read_responder;
  localparam int BB    = 32;
  localparam int AW    = 12;
  localparam int DW    = BB * 8;
  localparam int DEPTH = 1 << AW;

  logic clock  = 1'b0;
  logic areset = 1'b0;
  logic debug_state;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mem_read_responder_if #(.BEAT_BYTES(BB), .SRAM_ADDR_BITS(AW)) bus();

  mem_read_responder #(.BEAT_BYTES(BB), .SRAM_ADDR_BITS(AW)) dut (
    .clock       (clock),
    .areset      (areset),
    .bus         (bus.slave),
    .debug_state (debug_state)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] seen_addr_q[$];
  int            issued_cnt = 0;
  int            popped_cnt = 0;
  int            err_cnt    = 0;
  int            err_exp    = 0;
  bit            rand_ready = 1'b0;
  bit            prev_hold  = 1'b0;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] mon_exp;
  logic [AW-1:0] mon_addr;

  always @(posedge clock) begin
    if (bus.sram_rd_en) bus.sram_rd_data <= sram[bus.sram_rd_addr];
  end

  // Monitor: read addresses, beat data/order, hold stability and buffering bound.
  always @(negedge clock) begin
    if (!areset) begin
      prev_hold  = 1'b0;
      issued_cnt = popped_cnt;
    end else begin
      if (bus.sram_rd_en || bus.data_valid) begin
        n_cmp++;
        if (issued_cnt - popped_cnt > 2) begin
          n_fail++;
          $display("FAIL outstanding: %0d beats buffered or in flight, required at most 2", issued_cnt - popped_cnt);
        end
      end
      if (prev_hold) begin
        n_cmp++;
        if (bus.data_valid !== 1'b1 || bus.data !== prev_data) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", bus.data_valid, bus.data, prev_data);
        end
      end
      if (bus.sram_rd_en) begin
        seen_addr_q.push_back(bus.sram_rd_addr);
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_addr: read of %0d issued, required no read", bus.sram_rd_addr);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          if (bus.sram_rd_addr !== mon_addr) begin
            n_fail++;
            $display("FAIL rd_addr: got %0d, required %0d", bus.sram_rd_addr, mon_addr);
          end
        end
        issued_cnt++;
      end
      if (bus.data_valid && bus.data_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_data: beat %h delivered, required no beat", bus.data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.data !== mon_exp) begin
            n_fail++;
            $display("FAIL beat_data: got %h, required %h", bus.data, mon_exp);
          end
        end
        popped_cnt++;
      end
      if (bus.err) err_cnt++;
      prev_hold = bus.data_valid && !bus.data_ready;
      prev_data = bus.data;
    end
  end

  task automatic send_req(input logic [63:0] addr, input logic [33:0] len, output bit ok, output int waited);
    logic [63:0] beats;
    logic [63:0] idx;
    logic [AW-1:0] a;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
      waited++;
      if (rand_ready) bus.data_ready = ($urandom_range(0, 3) != 0);
    end
    if (!ok) return;
    beats = ({30'b0, len} + 64'(BB - 1)) / 64'(BB);
    idx   = addr / 64'(BB);
    for (int i = 0; i < int'(beats); i++) begin
      a = AW'((idx + 64'(i)) % 64'(DEPTH));
      exp_addr_q.push_back(a);
      exp_q.push_back(sram[a]);
    end
    if (addr % 64'(BB) != 64'd0) err_exp++;
    bus.req_addr_address = addr;
    bus.req_len          = len;
    bus.req_valid        = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && bus.inProgress === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
      if (rand_ready) bus.data_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_reset();
    areset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.inProgress, bus.data_valid, bus.sram_rd_en, bus.err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy/prog/valid/en/err=%b, required 00000",
               {bus.req_ready, bus.inProgress, bus.data_valid, bus.sram_rd_en, bus.err});
    end
    n_cmp++;
    if (bus.data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0", bus.data);
    end
    @(negedge clock);
    areset = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b, required 0", bus.req_ready);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b, required 1", bus.req_ready);
    end
  endtask

  task automatic test_basic();
    logic [8:1] en_v, valid_v, prog_v, rdy_v;
    logic [AW-1:0] addr_v [1:8];
    logic [4*AW-1:0] addr_got, addr_req;
    bit ok;
    int w;
    int e0 = err_cnt;
    bus.data_ready = 1'b1;
    send_req(64'h40, 34'd128, ok, w);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL basic_accept: req_ready never 1, required 1"); end
    for (int c = 1; c <= 8; c++) begin
      en_v[c] = bus.sram_rd_en; addr_v[c] = bus.sram_rd_addr; valid_v[c] = bus.data_valid;
      prog_v[c] = bus.inProgress; rdy_v[c] = bus.req_ready;
      @(posedge clock); #1;
    end
    addr_got = {addr_v[1], addr_v[2], addr_v[3], addr_v[4]};
    addr_req = {AW'(2), AW'(3), AW'(4), AW'(5)};
    n_cmp++;
    if (en_v !== 8'b0000_1111) begin n_fail++; $display("FAIL basic_rd_en: cycles8..1=%b, required 00001111", en_v); end
    n_cmp++;
    if (addr_got !== addr_req) begin n_fail++; $display("FAIL basic_rd_addr: got %h, required %h", addr_got, addr_req); end
    n_cmp++;
    if (valid_v !== 8'b0011_1100) begin n_fail++; $display("FAIL basic_valid: cycles8..1=%b, required 00111100", valid_v); end
    n_cmp++;
    if (prog_v !== 8'b0011_1111) begin n_fail++; $display("FAIL basic_inprogress: cycles8..1=%b, required 00111111", prog_v); end
    n_cmp++;
    if (rdy_v !== 8'b1100_0000) begin n_fail++; $display("FAIL basic_req_ready: cycles8..1=%b, required 11000000", rdy_v); end
    n_cmp++;
    if (err_cnt != e0) begin n_fail++; $display("FAIL basic_err: %0d pulses, required 0", err_cnt - e0); end
  endtask

  task automatic test_len40();
    bit ok, done;
    int w;
    int p0 = popped_cnt;
    int i0 = issued_cnt;
    bus.data_ready = 1'b1;
    send_req(64'h200, 34'd40, ok, w);
    wait_done(200, done);
    n_cmp++;
    if (!(ok && done)) begin n_fail++; $display("FAIL len40_done: accepted=%b finished=%b, required 1 1", ok, done); end
    n_cmp++;
    if (popped_cnt - p0 != 2) begin n_fail++; $display("FAIL len40_beats: got %0d, required 2", popped_cnt - p0); end
    n_cmp++;
    if (issued_cnt - i0 != 2) begin n_fail++; $display("FAIL len40_reads: got %0d, required 2", issued_cnt - i0); end
  endtask

  task automatic test_len0();
    bit ok;
    int w;
    logic any;
    int i0 = issued_cnt;
    bus.data_ready = 1'b1;
    send_req(64'h80, 34'd0, ok, w);
    n_cmp++;
    if (bus.req_ready !== 1'b1 || !ok) begin n_fail++; $display("FAIL len0_ready: got %b, required 1", bus.req_ready); end
    any = 1'b0;
    for (int c = 0; c < 4; c++) begin
      any = any | bus.sram_rd_en | bus.data_valid | bus.inProgress;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (any !== 1'b0) begin n_fail++; $display("FAIL len0_quiet: en|valid|inProgress=%b, required 0", any); end
    n_cmp++;
    if (issued_cnt != i0) begin n_fail++; $display("FAIL len0_reads: got %0d, required 0", issued_cnt - i0); end
  endtask

  task automatic test_stall();
    bit ok, done;
    int w;
    logic [DW-1:0] held;
    int p0 = popped_cnt;
    bus.data_ready = 1'b1;
    send_req(64'h300, 34'd256, ok, w);
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (popped_cnt - p0 >= 2) begin done = 1'b1; break; end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (!(ok && done)) begin n_fail++; $display("FAIL stall_start: accepted=%b streaming=%b, required 1 1", ok, done); end
    bus.data_ready = 1'b0;
    @(posedge clock); #1;
    held = bus.data;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (bus.data_valid !== 1'b1 || bus.data !== held) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", bus.data_valid, bus.data, held);
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (issued_cnt - popped_cnt > 2) begin n_fail++; $display("FAIL stall_outstanding: %0d, required at most 2", issued_cnt - popped_cnt); end
    bus.data_ready = 1'b1;
    wait_done(200, done);
    n_cmp++;
    if (!done || popped_cnt - p0 != 8) begin n_fail++; $display("FAIL stall_beats: got %0d, required 8", popped_cnt - p0); end
  endtask

  task automatic test_wrap();
    bit ok, done;
    int w;
    bus.data_ready = 1'b1;
    seen_addr_q.delete();
    send_req(64'h1FFE0, 34'd64, ok, w);
    wait_done(200, done);
    n_cmp++;
    if (seen_addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d reads, required 2", seen_addr_q.size());
    end else if (seen_addr_q[0] !== AW'(4095) || seen_addr_q[1] !== AW'(0)) begin
      n_fail++;
      $display("FAIL wrap_addr: got %0d,%0d, required 4095,0", seen_addr_q[0], seen_addr_q[1]);
    end
  endtask

  task automatic test_misaligned();
    bit ok, done;
    int w;
    int e0 = err_cnt;
    int p0 = popped_cnt;
    bus.data_ready = 1'b1;
    seen_addr_q.delete();
    send_req(64'h44, 34'd64, ok, w);
    wait_done(200, done);
    n_cmp++;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL misaligned_err: %0d pulse cycles, required 1", err_cnt - e0); end
    n_cmp++;
    if (seen_addr_q.size() == 0 || seen_addr_q[0] !== AW'(2)) begin
      n_fail++;
      $display("FAIL misaligned_addr: %0d reads, first %0d, required first 2", seen_addr_q.size(),
               (seen_addr_q.size() == 0) ? 0 : int'(seen_addr_q[0]));
    end
    n_cmp++;
    if (popped_cnt - p0 != 2) begin n_fail++; $display("FAIL misaligned_beats: got %0d, required 2", popped_cnt - p0); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, done;
    int w1, w2;
    int p0 = popped_cnt;
    bus.data_ready = 1'b1;
    send_req(64'h800, 34'd64, ok1, w1);
    send_req(64'h840, 34'd64, ok2, w2);
    n_cmp++;
    if (!(ok1 && ok2) || w2 != 4) begin
      n_fail++;
      $display("FAIL b2b_gap: second request waited %0d cycles, required 4", w2);
    end
    wait_done(200, done);
    n_cmp++;
    if (!done || popped_cnt - p0 != 4) begin n_fail++; $display("FAIL b2b_beats: got %0d, required 4", popped_cnt - p0); end
  endtask

  task automatic test_random();
    bit ok, done;
    int w;
    int p0 = popped_cnt;
    int want = 0;
    int timeouts = 0;
    logic [63:0] addr;
    logic [33:0] len;
    rand_ready = 1'b1;
    for (int r = 0; r < 24; r++) begin
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) addr[4:0] = 5'd0;
      len = 34'($urandom_range(0, 300));
      want += int'((len + 34'(BB - 1)) / 34'(BB));
      send_req(addr, len, ok, w);
      wait_done(2000, done);
      if (!(ok && done)) timeouts++;
    end
    rand_ready = 1'b0;
    bus.data_ready = 1'b1;
    n_cmp++;
    if (timeouts != 0) begin n_fail++; $display("FAIL random_timeout: %0d requests stuck, required 0", timeouts); end
    n_cmp++;
    if (popped_cnt - p0 != want) begin n_fail++; $display("FAIL random_beats: got %0d, required %0d", popped_cnt - p0, want); end
  endtask

  task automatic test_reset_mid();
    bit ok, reached;
    int w, p1;
    logic any;
    int p0 = popped_cnt;
    bus.data_ready = 1'b1;
    send_req(64'h600, 34'd128, ok, w);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (popped_cnt - p0 >= 2) begin reached = 1'b1; break; end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (!(ok && reached)) begin n_fail++; $display("FAIL rstmid_start: accepted=%b beat2=%b, required 1 1", ok, reached); end
    areset = 1'b0;
    #1;
    exp_q.delete();
    exp_addr_q.delete();
    n_cmp++;
    if ({bus.req_ready, bus.inProgress, bus.data_valid, bus.sram_rd_en, bus.err} !== 5'b0 || bus.data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: rdy/prog/valid/en/err=%b data=%h, required 00000 and 0",
               {bus.req_ready, bus.inProgress, bus.data_valid, bus.sram_rd_en, bus.err}, bus.data);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    areset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b, required 1", bus.req_ready); end
    p1 = popped_cnt;
    any = 1'b0;
    for (int c = 0; c < 10; c++) begin
      any = any | bus.data_valid | bus.sram_rd_en | bus.inProgress;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (any !== 1'b0 || popped_cnt != p1) begin
      n_fail++;
      $display("FAIL rstmid_stale: activity=%b beats=%0d, required 0 and 0", any, popped_cnt - p1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid        = 1'b0;
    bus.req_len          = '0;
    bus.req_addr_address = '0;
    bus.data_ready       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < DW / 32; k++) sram[i][k*32 +: 32] = $urandom;
    end
    test_reset();
    test_basic();
    test_len40();
    test_len0();
    test_stall();
    test_wrap();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d beats and %0d reads never seen, required 0 0", exp_q.size(), exp_addr_q.size());
    end
    n_cmp++;
    if (err_cnt != err_exp) begin n_fail++; $display("FAIL err_total: got %0d pulse cycles, required %0d", err_cnt, err_exp); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_read_responder.md
MEM_READ_RESPONDER -- requirements
Module: mem_read_responder

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 32, meaning bytes per data beat (power of two, at least 1).
REQ-002 SHALL have parameter SRAM_ADDR_BITS, default 12, meaning the beat-index width of the backing SRAM (depth 2^SRAM_ADDR_BITS beats).
REQ-003 SHALL have port clock  input  1  meaning the single clock; all logic rises on posedge.
REQ-004 SHALL have port areset  input  1  meaning reset, asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have port req_valid  input  1  meaning a read request is offered.
REQ-006 SHALL have port req_ready  output  1  meaning the block accepts a request.
REQ-007 SHALL have port req_len  input  34  meaning request length in bytes.
REQ-008 SHALL have port req_addr_address  input  64  meaning request byte address.
REQ-009 SHALL have port inProgress  output  1  meaning an accepted request still has beats left to deliver.
REQ-010 SHALL have port data_valid  output  1  meaning the data beat is valid.
REQ-011 SHALL have port data_ready  input  1  meaning the consumer takes the beat.
REQ-012 SHALL have port data  output  BEAT_BYTES*8  meaning the beat payload.
REQ-013 SHALL have port sram_rd_en  output  1  meaning an SRAM read strobe.
REQ-014 SHALL have port sram_rd_addr  output  SRAM_ADDR_BITS  meaning the SRAM beat index.
REQ-015 SHALL have port sram_rd_data  input  BEAT_BYTES*8  meaning SRAM read data, valid exactly 1 cycle after sram_rd_en.
REQ-016 SHALL have port err  output  1  meaning a 1-cycle pulse flagging a misaligned request.

Function
REQ-017 SHALL implement states IDLE and STREAM.
REQ-018 SHALL drive req_ready=1 only in IDLE.
REQ-019 SHALL treat a request as fired when req_valid and req_ready are both 1 on a rising edge.
REQ-020 SHALL, on fire, latch the beat index = req_addr_address[SRAM_ADDR_BITS+log2(BEAT_BYTES)-1 : log2(BEAT_BYTES)] and beats_left = ceil(req_len/BEAT_BYTES).
REQ-021 SHALL, on fire with nonzero beats_left, enter STREAM with inProgress=1 from the next cycle.
REQ-022 SHALL, on fire with req_len=0, remain in IDLE and emit no beats; inProgress stays 0.
REQ-023 SHALL, on fire with a nonzero low address byte offset, pulse err for 1 cycle, ignore the offset bits, and serve the request normally.
REQ-024 SHALL buffer beats in a 2-entry FIFO.
REQ-025 SHALL assert sram_rd_en in STREAM only while reads remain unissued and (FIFO occupancy + reads in flight) < 2.
REQ-026 SHALL increment the beat index after each issued read, wrapping modulo 2^SRAM_ADDR_BITS.
REQ-027 SHALL write sram_rd_data into the FIFO on the cycle after each sram_rd_en.
REQ-028 SHALL drive data_valid whenever the FIFO is non-empty, with data equal to the FIFO head.
REQ-029 SHALL pop the FIFO head only when data_valid and data_ready are both 1.
REQ-030 SHALL hold data and data_valid stable while data_valid=1 and data_ready=0.
REQ-031 SHALL give first-beat latency: fire at cycle 0, sram_rd_en at cycle 1, data_valid at cycle 3.
REQ-032 SHALL sustain 1 beat per cycle once data_ready is held at 1.
REQ-033 SHALL handle a FIFO push and pop in the same cycle, leaving occupancy unchanged.
REQ-034 SHALL, on handshake of the last beat, return to IDLE with inProgress=0 and req_ready=1 in the next cycle, with no idle bubble beyond that.
REQ-035 SHALL never deliver more than beats_left beats per request, and never drop or duplicate a beat.

Reset
REQ-036 SHALL, while areset=0, asynchronously force state=IDLE, FIFO empty, in-flight reads discarded, req_ready=0, inProgress=0, data_valid=0, sram_rd_en=0, err=0, and data=0.
REQ-037 SHALL, on the first rising edge after areset returns to 1, drive req_ready=1.
REQ-038 SHALL, if reset is asserted mid-request, deliver none of that request's remaining beats after reset is released.

Verification
REQ-039 SHALL cover: addr=0x40, len=128, BEAT_BYTES=32, data_ready=1 -> sram_rd_addr 2,3,4,5, then 4 beats on consecutive cycles starting at cycle 3, with inProgress 1 from cycle 1 until the 4th beat handshakes.
REQ-040 SHALL cover: len=40 -> exactly 2 beats delivered.
REQ-041 SHALL cover: len=0 -> no sram_rd_en, no data_valid, and req_ready=1 on the next cycle.
REQ-042 SHALL cover: data_ready=0 for 5 cycles mid-stream -> at most 2 reads outstanding, data held stable, and the beat order preserved.
REQ-043 SHALL cover: addr=0x1FFE0 at SRAM_ADDR_BITS=12, len=64 -> sram_rd_addr 4095 then 0; and addr=0x44 -> err pulses once.
REQ-044 SHALL cover: areset asserted at beat 2 of 4 -> all outputs 0 immediately, req_ready=1 after release, and no stale beats delivered.
